// File: rtl/gb_serial.sv
// Game Boy serial link port: SB (FF01) shift register and SC (FF02) control.
// Shifts SB out MSB-first while sampling sin_i; raises irq_serial when the byte completes.
module gb_serial #(
   parameter int unsigned SERIAL_DIV = 128
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] addr,
   input  logic [7:0]  data_i,
   input  logic        wren,
   output logic [7:0]  data_o,
   output logic        irq_serial,
   output logic        sclk_o,
   output logic        sout_o,
   input  logic        sclk_i,
   input  logic        sin_i
);

   localparam int unsigned DW = $clog2(SERIAL_DIV);
   localparam logic [DW-1:0] DIV_LAST = DW'(SERIAL_DIV - 1);
   localparam logic [DW-1:0] DIV_HALF = DW'(SERIAL_DIV / 2);
   localparam logic [DW-1:0] HALF_M1  = DW'(SERIAL_DIV / 2 - 1);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   state_t          state_q, state_d;
   logic            int_q, int_d;
   logic [7:0]      sb_q, sb_d;
   logic [DW-1:0]   div_q, div_d;
   logic [2:0]      bit_q, bit_d;
   logic            irq_q, irq_d;
   logic            sin_meta_q, sin_s_q;
   logic            sclk_meta_q, sclk_s_q, sclk_prev_q;

   logic            busy, wr_sb, wr_sc, sclk_rise, shift_en;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         int_q       <= 1'b0;
         sb_q        <= '0;
         div_q       <= '0;
         bit_q       <= '0;
         irq_q       <= 1'b0;
         sin_meta_q  <= 1'b1;
         sin_s_q     <= 1'b1;
         sclk_meta_q <= 1'b1;
         sclk_s_q    <= 1'b1;
         sclk_prev_q <= 1'b1;
      end else begin
         state_q     <= state_d;
         int_q       <= int_d;
         sb_q        <= sb_d;
         div_q       <= div_d;
         bit_q       <= bit_d;
         irq_q       <= irq_d;
         sin_meta_q  <= sin_i;
         sin_s_q     <= sin_meta_q;
         sclk_meta_q <= sclk_i;
         sclk_s_q    <= sclk_meta_q;
         sclk_prev_q <= sclk_s_q;
      end
   end

   assign busy      = (state_q == ST_BUSY);
   assign wr_sb     = wren && (addr == 16'hFF01);
   assign wr_sc     = wren && (addr == 16'hFF02);
   assign sclk_rise = sclk_s_q & ~sclk_prev_q;
   assign shift_en  = busy && (int_q ? (div_q == HALF_M1) : sclk_rise);

   always_comb begin
      state_d = state_q;
      int_d   = int_q;
      sb_d    = sb_q;
      div_d   = div_q;
      bit_d   = bit_q;
      irq_d   = 1'b0;

      if (busy && int_q) begin
         div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      end

      // An SC write owns the whole edge: it suppresses any coincident shift and its irq.
      if (wr_sc) begin
         state_d = data_i[7] ? ST_BUSY : ST_IDLE;
         int_d   = data_i[0];
         div_d   = '0;
         bit_d   = '0;
      end else if (shift_en) begin
         sb_d = {sb_q[6:0], sin_s_q};
         if (bit_q == 3'd7) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            div_d   = '0;
            irq_d   = 1'b1;
         end else begin
            bit_d = bit_q + 3'd1;
         end
      end

      if (wr_sb && !busy) begin
         sb_d = data_i;
      end
   end

   always_comb begin
      data_o = 8'hFF;
      if (addr == 16'hFF01) begin
         data_o = sb_q;
      end else if (addr == 16'hFF02) begin
         data_o = {busy, 6'b111111, int_q};
      end
   end

   assign irq_serial = irq_q;
   assign sclk_o     = !(busy && int_q && (div_q < DIV_HALF));
   assign sout_o     = sb_q[7];

endmodule

// File: tb/tb_gb_serial.sv
// Randomized self-checking bench for gb_serial against a bit-level transfer model.
module tb_gb_serial;

   localparam int unsigned DIV = 128;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] addr = 16'h0000;
   logic [7:0]  data_i = 8'h00;
   logic        wren = 1'b0;
   logic [7:0]  data_o;
   logic        irq_serial, sclk_o, sout_o;
   logic        sclk_i = 1'b1;
   logic        sin_drv = 1'b0;
   logic        loop_en = 1'b0;
   logic        sin_w;

   int checks = 0;
   int failures = 0;
   int irq_cnt = 0;
   int sclk_low = 0;

   assign sin_w = loop_en ? sout_o : sin_drv;

   always #5 clk = ~clk;

   gb_serial #(.SERIAL_DIV(DIV)) dut (
      .clk        (clk),
      .reset      (reset),
      .addr       (addr),
      .data_i     (data_i),
      .wren       (wren),
      .data_o     (data_o),
      .irq_serial (irq_serial),
      .sclk_o     (sclk_o),
      .sout_o     (sout_o),
      .sclk_i     (sclk_i),
      .sin_i      (sin_w)
   );

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (irq_serial) irq_cnt++;
         if (!sclk_o) sclk_low++;
      end
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      addr = a; data_i = d; wren = 1'b1;
      @(posedge clk); #1;
      wren = 1'b0;
      if (irq_serial) irq_cnt++;
   endtask

   task automatic rd(input logic [15:0] a, output logic [7:0] d);
      addr = a;
      #1;
      d = data_o;
   endtask

   // Model: after 8 shifts SB holds the sampled bits, first sample in the MSB.
   function automatic logic [7:0] collect(input logic [7:0] bits);
      logic [7:0] r = 8'h00;
      for (int k = 0; k < 8; k++) r = {r[6:0], bits[k]};
      return r;
   endfunction

   task automatic run_internal(input logic [7:0] orig, input logic [7:0] bits, input logic loop);
      logic [7:0] v;
      int irq_at;
      loop_en = loop;
      wr(16'hFF01, orig);
      wr(16'hFF02, 8'h81);
      rd(16'hFF02, v);
      chk("sc_busy", 16'(v), 16'h00FF);
      chk("sclk_start_low", 16'(sclk_o), 16'h0000);
      irq_cnt = 0;
      irq_at = -1;
      for (int n = 1; n <= 1000; n++) begin
         if (!loop && ((n - 1) % DIV == 0) && ((n - 1) / DIV < 8)) sin_drv = bits[(n - 1) / DIV];
         @(posedge clk); #1;
         if (irq_serial) begin irq_cnt++; irq_at = n; end
         if ((n % DIV == DIV / 2 - 1) && (n / DIV < 8)) chk("sout_bit", 16'(sout_o), 16'(orig[7 - n / DIV]));
         if ((n % 32 == 0) && (n < 960)) chk("sclk_phase", 16'(sclk_o), 16'((n % DIV) >= DIV / 2));
         if (n == 959) chk("sc_before_done", 16'(data_o), 16'h00FF);
         if (n == 960) chk("sc_done", 16'(data_o), 16'h007F);
      end
      chk("irq_count", 16'(irq_cnt), 16'd1);
      chk("irq_cycle", 16'(irq_at), 16'd960);
      chk("sclk_idle", 16'(sclk_o), 16'h0001);
      rd(16'hFF01, v);
      chk("sb_final", 16'(v), 16'(loop ? orig : collect(bits)));
      loop_en = 1'b0;
   endtask

   task automatic run_external(input logic [7:0] orig, input logic [7:0] bits, input int idle);
      logic [7:0] v;
      sin_drv = 1'b0;
      wr(16'hFF01, orig);
      wr(16'hFF02, 8'h80);
      irq_cnt = 0;
      sclk_low = 0;
      tick(idle);
      rd(16'hFF02, v);
      chk("ext_wait_sc", 16'(v), 16'h00FE);
      chk("ext_wait_irq", 16'(irq_cnt), 16'd0);
      for (int k = 0; k < 8; k++) begin
         sin_drv = bits[k];
         sclk_i = 1'b0; tick(10);
         sclk_i = 1'b1; tick(10);
      end
      tick(5);
      chk("ext_irq_count", 16'(irq_cnt), 16'd1);
      chk("ext_sclk_low", 16'(sclk_low), 16'd0);
      rd(16'hFF01, v);
      chk("ext_sb", 16'(v), 16'(collect(bits)));
      rd(16'hFF02, v);
      chk("ext_sc", 16'(v), 16'h007E);
   endtask

   initial begin
      logic [7:0] v, orig, part;
      logic s;

      #12;
      rd(16'hFF01, v); chk("rst_sb", 16'(v), 16'h0000);
      rd(16'hFF02, v); chk("rst_sc", 16'(v), 16'h007E);
      rd(16'hFF10, v); chk("rst_other", 16'(v), 16'h00FF);
      chk("rst_sclk", 16'(sclk_o), 16'h0001);
      chk("rst_irq", 16'(irq_serial), 16'h0000);
      chk("rst_sout", 16'(sout_o), 16'h0000);
      @(posedge clk); #1;
      reset = 1'b1;

      irq_cnt = 0;
      sin_drv = 1'b1;
      for (int k = 0; k < 4; k++) begin
         sclk_i = 1'b0; tick(10);
         sclk_i = 1'b1; tick(10);
      end
      rd(16'hFF01, v); chk("idle_ext_edges_sb", 16'(v), 16'h0000);
      chk("idle_ext_edges_irq", 16'(irq_cnt), 16'd0);
      wr(16'hFF01, 8'h5A);
      rd(16'hFF01, v); chk("idle_sb_load", 16'(v), 16'h005A);

      run_internal(8'hA5, 8'h00, 1'b1);
      run_internal(8'h3C, 8'hFF, 1'b0);
      for (int t = 0; t < 4; t++) run_internal(8'($urandom), 8'($urandom), 1'b0);

      run_external(8'hFF, 8'h00, 2000);
      for (int t = 0; t < 3; t++) run_external(8'($urandom), 8'($urandom), 50);

      // SC write on the same edge as the 8th shift
      wr(16'hFF01, 8'($urandom));
      wr(16'hFF02, 8'h81);
      irq_cnt = 0;
      tick(959);
      wr(16'hFF02, 8'h81);
      chk("wins_irq_now", 16'(irq_serial), 16'h0000);
      rd(16'hFF02, v); chk("wins_sc", 16'(v), 16'h00FF);
      tick(200);
      chk("wins_irq_later", 16'(irq_cnt), 16'd0);
      wr(16'hFF02, 8'h00);
      rd(16'hFF02, v); chk("wins_abort_sc", 16'(v), 16'h007E);

      // Abort after three shifts
      orig = 8'($urandom);
      s = 1'($urandom_range(0, 1));
      sin_drv = s;
      wr(16'hFF01, orig);
      wr(16'hFF02, 8'h81);
      irq_cnt = 0;
      tick(DIV / 2 + 2 * DIV + 10);
      part = {orig[4:0], s, s, s};
      wr(16'hFF01, ~orig);
      rd(16'hFF01, v); chk("busy_sb_write_ignored", 16'(v), 16'(part));
      wr(16'hFF02, 8'h01);
      chk("abort_sclk", 16'(sclk_o), 16'h0001);
      rd(16'hFF02, v); chk("abort_sc", 16'(v), 16'h007F);
      sclk_low = 0;
      tick(1200);
      chk("abort_irq", 16'(irq_cnt), 16'd0);
      chk("abort_sclk_low", 16'(sclk_low), 16'd0);
      rd(16'hFF01, v); chk("abort_sb_partial", 16'(v), 16'(part));
      wr(16'hFF01, 8'h55);
      rd(16'hFF01, v); chk("abort_sb_load", 16'(v), 16'h0055);

      // Reset mid-transfer
      wr(16'hFF01, 8'($urandom) | 8'h80);
      wr(16'hFF02, 8'h81);
      tick(DIV / 2 + 4 * DIV + 10);
      addr = 16'hFF01;
      reset = 1'b0;
      #1;
      chk("midrst_sb", 16'(data_o), 16'h0000);
      chk("midrst_sclk", 16'(sclk_o), 16'h0001);
      chk("midrst_irq", 16'(irq_serial), 16'h0000);
      chk("midrst_sout", 16'(sout_o), 16'h0000);
      rd(16'hFF02, v); chk("midrst_sc", 16'(v), 16'h007E);
      tick(3);
      reset = 1'b1;
      irq_cnt = 0;
      sclk_low = 0;
      tick(1200);
      chk("midrst_irq_after", 16'(irq_cnt), 16'd0);
      chk("midrst_sclk_after", 16'(sclk_low), 16'd0);
      rd(16'hFF01, v); chk("midrst_sb_after", 16'(v), 16'h0000);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
